// File: rtl/bus_mem_io_if.sv
// Core/host-facing bus of the memory and console responder.
// The slave modport belongs to bus_mem_io; the master modport belongs to whoever drives it.
interface bus_mem_io_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport slave (
    input  addr, wdata, we, tx_ready, rx_data, rx_valid,
    output rdata, tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr, wdata, we, tx_ready, rx_data, rx_valid,
    input  rdata, tx_data, tx_valid, rx_ready
  );
endinterface

// File: rtl/bus_mem_io.sv
// Memory-bus responder: byte RAM below IO_BASE, plus a console made of
// a TX FIFO (core to host), an RX FIFO (host to core) and a status register.
module bus_mem_io #(
  parameter logic [7:0]  IO_BASE    = 8'hF0,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  bus_mem_io_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned IW = PW - 1;
  localparam logic [7:0]  AddrTx   = IO_BASE;
  localparam logic [7:0]  AddrRx   = IO_BASE + 8'd1;
  localparam logic [7:0]  AddrStat = IO_BASE + 8'd2;

  logic [7:0] ram_q [256];
  logic [7:0] tx_mem_q [FIFO_DEPTH];
  logic [7:0] rx_mem_q [FIFO_DEPTH];

  logic [PW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic          tx_full, tx_empty, tx_push, tx_pop, tx_ovf_q, tx_ovf_d;
  logic          rx_full, rx_empty, rx_push, rx_pop;

  logic [7:0] addr_q;
  logic       we_q, seen_q;
  logic       entry;
  logic [7:0] rdata_q, rdata_d;

  // Side effects fire only when (addr, we) changes, so held strobes act once.
  assign entry = !seen_q || (bus.addr != addr_q) || (bus.we != we_q);

  assign tx_empty = (tx_wp_q == tx_rp_q);
  assign tx_full  = (tx_wp_q[PW-1] != tx_rp_q[PW-1]) && (tx_wp_q[IW-1:0] == tx_rp_q[IW-1:0]);
  assign rx_empty = (rx_wp_q == rx_rp_q);
  assign rx_full  = (rx_wp_q[PW-1] != rx_rp_q[PW-1]) && (rx_wp_q[IW-1:0] == rx_rp_q[IW-1:0]);

  always_comb begin
    tx_push  = entry && bus.we && (bus.addr == AddrTx) && !tx_full;
    tx_ovf_d = tx_ovf_q || (entry && bus.we && (bus.addr == AddrTx) && tx_full);
    tx_pop   = !tx_empty && bus.tx_ready;
    rx_push  = bus.rx_valid && !rx_full;
    rx_pop   = entry && !bus.we && (bus.addr == AddrRx) && !rx_empty;
    tx_wp_d  = tx_wp_q + {{(PW-1){1'b0}}, tx_push};
    tx_rp_d  = tx_rp_q + {{(PW-1){1'b0}}, tx_pop};
    rx_wp_d  = rx_wp_q + {{(PW-1){1'b0}}, rx_push};
    rx_rp_d  = rx_rp_q + {{(PW-1){1'b0}}, rx_pop};
  end

  always_comb begin
    rdata_d = 8'h00;
    if (bus.addr < IO_BASE) begin
      rdata_d = ram_q[bus.addr];
    end else begin
      case (bus.addr)
        AddrRx: begin
          // A held RXDATA read keeps returning the byte it popped on entry.
          if (!bus.we) begin
            if (!entry)        rdata_d = rdata_q;
            else if (rx_empty) rdata_d = 8'h00;
            else               rdata_d = rx_mem_q[rx_rp_q[IW-1:0]];
          end
        end
        AddrStat: rdata_d = {5'b0, tx_ovf_q, tx_full, !rx_empty};
        default:  rdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_ovf_q <= 1'b0;
      addr_q   <= 8'h00;
      we_q     <= 1'b0;
      seen_q   <= 1'b0;
      rdata_q  <= 8'h00;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_ovf_q <= tx_ovf_d;
      addr_q   <= bus.addr;
      we_q     <= bus.we;
      seen_q   <= 1'b1;
      rdata_q  <= rdata_d;
    end
  end

  // Storage arrays carry no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (bus.we && (bus.addr < IO_BASE)) ram_q[bus.addr] <= bus.wdata;
    if (!rst && tx_push) tx_mem_q[tx_wp_q[IW-1:0]] <= bus.wdata;
    if (!rst && rx_push) rx_mem_q[rx_wp_q[IW-1:0]] <= bus.rx_data;
  end

  assign bus.rdata    = rdata_q;
  assign bus.tx_data  = tx_mem_q[tx_rp_q[IW-1:0]];
  assign bus.tx_valid = !tx_empty;
  assign bus.rx_ready = !rx_full;

endmodule
